button_event: RTL and testbench

- Consumes the debounced level from the button debouncer and turns it into single-cycle UI events: press, release, long-press and auto-repeat, plus a held level.
- Sits directly downstream of the debouncer. Feeds the control/register logic that needs edge events rather than levels.
- Timing is in milliseconds, derived from an internal prescaler. No other timebase is needed.

---
 rtl/button_event.sv | 162 ++++++++++++++++
 tb/tb_button_event.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_event.sv
// button_event: turns a debounced button level into one-cycle press/release/long-press/repeat
// pulses plus a held level. Define BTN_DOUBLE_CLICK_EN to enable double-click detection.
module button_event #(
  parameter bit          PRESS_LEVEL = 1'b0,
  parameter int unsigned PRESCALE    = 38000,
  parameter int unsigned LONG_MS     = 500,
  parameter int unsigned REPEAT_MS   = 100,
  parameter int unsigned DBL_MS      = 250
) (
  input  logic clk,
  input  logic n_reset,
  input  logic db_in,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic held,
  output logic double_click
);

  localparam int            PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(PRESCALE - 1);
  localparam logic [15:0]   LONG_LAST = 16'(LONG_MS - 1);
  localparam logic [15:0]   REP_LAST  = 16'(REPEAT_MS - 1);
  localparam logic [15:0]   MS_SAT    = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} state_t;

  state_t        state_reg, state_next;
  logic          db_q_reg;
  logic [PW-1:0] pre_reg, pre_next;
  logic [15:0]   ms_reg, ms_next;
  logic          press_reg, press_next;
  logic          release_reg, release_next;
  logic          long_reg, long_next;
  logic          repeat_reg, repeat_next;
  logic          held_reg, held_next;

  logic pressed_now, rise, fall, tick;

  assign pressed_now = (db_in == PRESS_LEVEL);
  assign rise        = pressed_now & ~db_q_reg;
  assign fall        = ~pressed_now & db_q_reg;
  assign tick        = (pre_reg == PRE_MAX);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg   <= IDLE;
      db_q_reg    <= 1'b0;
      pre_reg     <= '0;
      ms_reg      <= '0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      long_reg    <= 1'b0;
      repeat_reg  <= 1'b0;
      held_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      db_q_reg    <= pressed_now;
      pre_reg     <= pre_next;
      ms_reg      <= ms_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      long_reg    <= long_next;
      repeat_reg  <= repeat_next;
      held_reg    <= held_next;
    end
  end

  // A fall is checked before any timer expiry so release always wins the cycle.
  always_comb begin
    state_next   = state_reg;
    pre_next     = tick ? '0 : pre_reg + PW'(1);
    ms_next      = (tick && ms_reg != MS_SAT) ? ms_reg + 16'd1 : ms_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    long_next    = 1'b0;
    repeat_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rise) begin
          press_next = 1'b1;
          state_next = PRESSED;
          pre_next   = '0;
          ms_next    = '0;
        end
      end
      PRESSED: begin
        if (fall) begin
          release_next = 1'b1;
          state_next   = IDLE;
        end else if (tick && ms_reg == LONG_LAST) begin
          long_next  = 1'b1;
          state_next = LONG_HELD;
          ms_next    = '0;
        end
      end
      LONG_HELD: begin
        if (fall) begin
          release_next = 1'b1;
          state_next   = IDLE;
        end else if (REPEAT_MS != 0 && tick && ms_reg == REP_LAST) begin
          repeat_next = 1'b1;
          ms_next     = '0;
        end
      end
      default: state_next = IDLE;
    endcase
    held_next = (state_next != IDLE);
  end

  assign press         = press_reg;
  assign release_pulse = release_reg;
  assign long_press    = long_reg;
  assign repeat_pulse  = repeat_reg;
  assign held          = held_reg;

`ifdef BTN_DOUBLE_CLICK_EN
  logic [PW-1:0] gap_pre_reg;
  logic [15:0]   gap_ms_reg;
  logic          gap_armed_reg, pair_done_reg, dbl_reg;
  logic          gap_tick, gap_expired;

  assign gap_tick    = (gap_pre_reg == PRE_MAX);
  // Count the tick landing in this cycle, so a rise at exactly DBL_MS is already too late.
  assign gap_expired = ({1'b0, gap_ms_reg} + {16'd0, gap_tick}) >= 17'(DBL_MS);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      gap_pre_reg   <= '0;
      gap_ms_reg    <= '0;
      gap_armed_reg <= 1'b0;
      pair_done_reg <= 1'b0;
      dbl_reg       <= 1'b0;
    end else begin
      dbl_reg     <= 1'b0;
      gap_pre_reg <= gap_tick ? '0 : gap_pre_reg + PW'(1);
      if (gap_tick && gap_ms_reg != MS_SAT) gap_ms_reg <= gap_ms_reg + 16'd1;
      if (fall) begin
        gap_pre_reg   <= '0;
        gap_ms_reg    <= '0;
        // The release that closes a completed pair must not arm a new window.
        gap_armed_reg <= ~pair_done_reg;
      end else if (rise) begin
        if (gap_armed_reg && !gap_expired) begin
          dbl_reg       <= 1'b1;
          pair_done_reg <= 1'b1;
        end else begin
          pair_done_reg <= 1'b0;
        end
        gap_armed_reg <= 1'b0;
        gap_ms_reg    <= '0;
      end
    end
  end

  assign double_click = dbl_reg;
`else
  assign double_click = 1'b0;
`endif

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event: stimulus queues expected pulses, a negedge monitor checks them.
module tb_button_event;
  localparam int PRESCALE  = 4;
  localparam int LONG_MS   = 5;
  localparam int REPEAT_MS = 3;
  localparam int DBL_MS    = 10;
`ifdef BTN_DOUBLE_CLICK_EN
  localparam bit DBL_EN = 1'b1;
`else
  localparam bit DBL_EN = 1'b0;
`endif
  localparam logic [4:0] EV_PRESS = 5'b00001;
  localparam logic [4:0] EV_REL   = 5'b00010;
  localparam logic [4:0] EV_LONG  = 5'b00100;
  localparam logic [4:0] EV_REP   = 5'b01000;
  localparam logic [4:0] EV_DBL   = 5'b10000;

  logic clk = 1'b0;
  logic n_reset;
  logic db_in;
  logic press, rel, lp, rp, held, dbl;
  logic press0, rel0, lp0, rp0, held0, dbl0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int long0_cnt = 0;
  int rep0_cnt = 0;
  bit cnt0_en = 1'b0;

  typedef struct {
    int         cyc;
    logic [4:0] ev;
  } exp_t;
  exp_t exp_q[$];

  button_event #(.PRESS_LEVEL(1'b0), .PRESCALE(PRESCALE), .LONG_MS(LONG_MS),
                 .REPEAT_MS(REPEAT_MS), .DBL_MS(DBL_MS)) dut (
    .clk(clk), .n_reset(n_reset), .db_in(db_in),
    .press(press), .release_pulse(rel), .long_press(lp), .repeat_pulse(rp),
    .held(held), .double_click(dbl)
  );

  button_event #(.PRESS_LEVEL(1'b0), .PRESCALE(PRESCALE), .LONG_MS(LONG_MS),
                 .REPEAT_MS(0), .DBL_MS(DBL_MS)) dut0 (
    .clk(clk), .n_reset(n_reset), .db_in(db_in),
    .press(press0), .release_pulse(rel0), .long_press(lp0), .repeat_pulse(rp0),
    .held(held0), .double_click(dbl0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any pulse, or an expectation falling due, consumes one scoreboard entry.
  always @(negedge clk) begin
    logic [4:0] ev;
    exp_t e;
    ev = {dbl, rp, lp, rel, press};
    if (ev != 5'b0 || (exp_q.size() > 0 && exp_q[0].cyc <= cyc)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: cycle %0d got %b required none", cyc, ev);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.ev != ev) begin
          errors++;
          $display("FAIL event: cycle %0d got %b, required %b at cycle %0d", cyc, ev, e.ev, e.cyc);
        end else begin
          $display("event ok: cycle %0d ev %b", cyc, ev);
        end
      end
    end
    if (cnt0_en) begin
      if (lp0) long0_cnt++;
      if (rp0) rep0_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at cycle %0d", name, got, want, cyc);
    end else begin
      $display("check ok: %s = %0h at cycle %0d", name, got, cyc);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int c, input logic [4:0] e);
    exp_t x;
    x.cyc = c;
    x.ev  = e;
    exp_q.push_back(x);
  endtask

  initial begin
    int c;
    int p;
    int gaps[7];
    bit dexp[7];
    gaps = '{60, 20, 20, 44, 39, 10, 40};
    dexp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    n_reset = 1'b0;
    db_in   = 1'b0;

    // Reset with the button held: silent during reset, press one cycle after release.
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", {20'd0, dbl0, rp0, lp0, rel0, press0, held0, dbl, rp, lp, rel, press, held}, 32'd0);
    end
    c = cyc;
    n_reset = 1'b1;
    push(c + 1, EV_PRESS);
    tick_n(2);
    check("held_after_reset_press", held, 1);
    db_in = 1'b1;
    push(cyc + 1, EV_REL);
    tick_n(1);
    check("held_after_release", held, 0);
    tick_n(60);

    // Short press of 10 cycles.
    c = cyc;
    db_in = 1'b0;
    push(c + 1, EV_PRESS);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check("held_short", held, 1);
    end
    db_in = 1'b1;
    push(c + 11, EV_REL);
    tick_n(1);
    check("held_short_end", held, 0);
    tick_n(60);

    // Hold 60 cycles: long press then repeats every 12 cycles.
    c = cyc;
    p = c + 1;
    db_in = 1'b0;
    push(p, EV_PRESS);
    push(p + 20, EV_LONG);
    push(p + 32, EV_REP);
    push(p + 44, EV_REP);
    push(p + 56, EV_REP);
    tick_n(60);
    check("held_long", held, 1);
    db_in = 1'b1;
    push(c + 61, EV_REL);
    tick_n(61);

    // Release lands on the long-press expiry edge: release only.
    c = cyc;
    db_in = 1'b0;
    push(c + 1, EV_PRESS);
    tick_n(20);
    db_in = 1'b1;
    push(c + 21, EV_REL);
    tick_n(61);

    // Release one cycle later: long press then release back to back.
    c = cyc;
    db_in = 1'b0;
    push(c + 1, EV_PRESS);
    push(c + 21, EV_LONG);
    tick_n(21);
    db_in = 1'b1;
    push(c + 22, EV_REL);
    tick_n(61);

    // Hold 100 cycles; the REPEAT_MS=0 instance must give one long press and no repeats.
    long0_cnt = 0;
    rep0_cnt  = 0;
    cnt0_en   = 1'b1;
    c = cyc;
    p = c + 1;
    db_in = 1'b0;
    push(p, EV_PRESS);
    push(p + 20, EV_LONG);
    for (int k = 1; k <= 6; k++) push(p + 20 + 12 * k, EV_REP);
    tick_n(100);
    check("rep0_held", held0, 1);
    db_in = 1'b1;
    push(c + 101, EV_REL);
    tick_n(61);
    cnt0_en = 1'b0;
    check("rep0_long_count", long0_cnt, 1);
    check("rep0_repeat_count", rep0_cnt, 0);

    // Double-click gap table: gap in cycles before each 4-cycle press.
    for (int i = 0; i < 7; i++) begin
      tick_n(gaps[i]);
      c = cyc;
      db_in = 1'b0;
      push(c + 1, (DBL_EN && dexp[i]) ? (EV_PRESS | EV_DBL) : EV_PRESS);
      tick_n(4);
      db_in = 1'b1;
      push(c + 5, EV_REL);
    end
    tick_n(60);

    // Reset mid-press: outputs drop at once and no release follows.
    c = cyc;
    db_in = 1'b0;
    push(c + 1, EV_PRESS);
    tick_n(8);
    check("held_before_mid_reset", held, 1);
    n_reset = 1'b0;
    db_in = 1'b1;
    tick_n(1);
    check("mid_reset_outputs", {26'd0, dbl, rp, lp, rel, press, held}, 32'd0);
    tick_n(2);
    n_reset = 1'b1;
    tick_n(20);
    check("held_after_mid_reset", held, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
